ahbl_excl_monitor: RTL and testbench

AHB-Lite exclusive-access monitor placed directly downstream of ahbl_arbiter's dst_* port, in front of a memory slave. It tracks one reservation per master, indexed by hmaster, and suppresses failing exclusive writes before they reach the slave. It generates hexokay back to the arbiter. All other traffic passes through unchanged with zero added latency.

---
 rtl/ahbl_excl_monitor.sv | 155 +++++++++++++++
 tb/tb_ahbl_excl_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: one reservation per master, failing exclusive
// writes are turned into IDLE towards the slave and answered locally with OKAY.
module ahbl_excl_monitor #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int N_MASTERS = 2,
    parameter int W_GRANULE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);
    localparam int         W_IDX  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int         W_GRAN = W_ADDR - W_GRANULE;
    localparam logic [8:0] N_M    = 9'(N_MASTERS);

    logic [N_MASTERS-1:0] res_valid_q, res_valid_d, res_valid_eff, clr_now;
    logic [W_GRAN-1:0]    res_gran_q [N_MASTERS];
    logic [W_GRAN-1:0]    res_gran_d [N_MASTERS];

    logic              dph_valid_q, dph_valid_d;
    logic              dph_supp_q, dph_supp_d;
    logic              dph_excl_q, dph_excl_d;
    logic              dph_write_q, dph_write_d;
    logic [7:0]        dph_master_q, dph_master_d;
    logic [W_GRAN-1:0] dph_gran_q, dph_gran_d;

    logic [W_GRAN-1:0] a_gran;
    logic [W_IDX-1:0]  a_idx, d_idx;
    logic              a_mok, d_mok, a_match, excl_fail_a;
    logic              dph_done, dph_okay;

    assign a_gran = src_haddr[W_ADDR-1:W_GRANULE];
    assign a_idx  = src_hmaster[W_IDX-1:0];
    assign a_mok  = {1'b0, src_hmaster} < N_M;
    assign d_idx  = dph_master_q[W_IDX-1:0];
    assign d_mok  = {1'b0, dph_master_q} < N_M;

    // Suppressed phases answer locally; an idle data phase always reads as ready/OKAY.
    always_comb begin
        src_hready_resp = dst_hready_resp;
        src_hresp       = dst_hresp;
        if (!dph_valid_q || dph_supp_q) begin
            src_hready_resp = 1'b1;
            src_hresp       = 1'b0;
        end
    end

    assign dph_done    = dph_valid_q && src_hready_resp;
    assign dph_okay    = !src_hresp;
    assign src_hexokay = dph_valid_q && dph_excl_q && !dph_supp_q && !dst_hresp && src_hready_resp;

    // Clear mask of the write completing this cycle, forwarded into the address check.
    always_comb begin
        clr_now = '0;
        if (dph_done && dph_write_q) begin
            if (dph_supp_q) begin
                if (d_mok) clr_now[d_idx] = 1'b1;
            end else if (dph_okay) begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    if (res_gran_q[i] == dph_gran_q) clr_now[i] = 1'b1;
                end
            end
        end
    end

    assign res_valid_eff = res_valid_q & ~clr_now;
    assign a_match       = a_mok && res_valid_eff[a_idx] && (res_gran_q[a_idx] == a_gran);
    assign excl_fail_a   = src_htrans[1] && src_hexcl && src_hwrite && !a_match;

    assign dst_htrans    = excl_fail_a ? 2'b00 : src_htrans;
    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;
    assign src_hrdata    = dst_hrdata;

    always_comb begin
        res_valid_d = res_valid_eff;
        res_gran_d  = res_gran_q;
        if (dph_done && dph_excl_q && !dph_write_q && dph_okay && d_mok) begin
            res_valid_d[d_idx] = 1'b1;
            res_gran_d[d_idx]  = dph_gran_q;
        end
    end

    always_comb begin
        dph_valid_d  = dph_valid_q;
        dph_supp_d   = dph_supp_q;
        dph_excl_d   = dph_excl_q;
        dph_write_d  = dph_write_q;
        dph_master_d = dph_master_q;
        dph_gran_d   = dph_gran_q;
        if (src_hready) begin
            dph_valid_d  = src_htrans[1];
            dph_supp_d   = excl_fail_a;
            dph_excl_d   = src_htrans[1] && src_hexcl;
            dph_write_d  = src_hwrite;
            dph_master_d = src_hmaster;
            dph_gran_d   = a_gran;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= '0;
            for (int i = 0; i < N_MASTERS; i++) res_gran_q[i] <= '0;
            dph_valid_q  <= 1'b0;
            dph_supp_q   <= 1'b0;
            dph_excl_q   <= 1'b0;
            dph_write_q  <= 1'b0;
            dph_master_q <= '0;
            dph_gran_q   <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_gran_q   <= res_gran_d;
            dph_valid_q  <= dph_valid_d;
            dph_supp_q   <= dph_supp_d;
            dph_excl_q   <= dph_excl_d;
            dph_write_q  <= dph_write_d;
            dph_master_q <= dph_master_d;
            dph_gran_q   <= dph_gran_d;
        end
    end
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Directed bench for ahbl_excl_monitor with a small memory slave behind it.
module tb_ahbl_excl_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hready, hresp, hexokay;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hexcl, hmastlock;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [7:0]  hmaster;
    logic        dst_hready, s_hready_resp, s_hresp;
    logic [31:0] dst_haddr, dst_hwdata, s_hrdata;
    logic        dst_hwrite, dst_hmastlock;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahbl_excl_monitor #(.W_ADDR(32), .W_DATA(32), .N_MASTERS(2), .W_GRANULE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready(hready), .src_hready_resp(hready), .src_hresp(hresp),
        .src_haddr(haddr), .src_hwrite(hwrite), .src_htrans(htrans), .src_hsize(hsize),
        .src_hburst(hburst), .src_hprot(hprot), .src_hmastlock(hmastlock),
        .src_hwdata(hwdata), .src_hrdata(hrdata), .src_hexcl(hexcl),
        .src_hmaster(hmaster), .src_hexokay(hexokay),
        .dst_hready(dst_hready), .dst_hready_resp(s_hready_resp), .dst_hresp(s_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(s_hrdata)
    );

    // Memory slave: 'waits' wait states per transfer, or a two-cycle ERROR when err_mode is set.
    logic [31:0] mem [256];
    logic        s_dph, s_write, s_err, err_mode;
    logic [31:0] s_addr;
    logic [3:0]  s_cnt, waits;

    assign s_hready_resp = !(s_dph && s_cnt != 4'd0);
    assign s_hresp       = s_dph && s_err;
    assign s_hrdata      = mem[s_addr[9:2]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_dph <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_addr <= '0; s_cnt <= '0;
        end else if (dst_hready) begin
            s_dph   <= dst_htrans[1];
            s_write <= dst_hwrite;
            s_addr  <= dst_haddr;
            s_err   <= dst_htrans[1] && err_mode;
            s_cnt   <= !dst_htrans[1] ? 4'd0 : (err_mode ? 4'd1 : waits);
        end else if (s_cnt != 4'd0) begin
            s_cnt <= s_cnt - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (dst_hready && s_dph && s_write && !s_err) mem[s_addr[9:2]] <= dst_hwdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [1:0]  tr;
    logic        ok, resp;
    logic [31:0] rd;
    int          wc;

    // One non-pipelined transfer, starting and ending at a negedge with the bus idle.
    task automatic xfer(input logic [7:0] m, input logic [31:0] a, input logic w,
                        input logic x, input logic [31:0] wd);
        hmaster = m; haddr = a; hwrite = w; hexcl = x; htrans = 2'b10;
        #1 tr = dst_htrans;
        @(posedge clk);
        @(negedge clk);
        htrans = 2'b00; hexcl = 1'b0; hwdata = wd;
        wc = 0;
        while (!hready && wc < 20) begin
            @(negedge clk);
            wc++;
        end
        if (wc >= 20) chk("timeout", 32'(wc), 32'd0);
        ok = hexokay; resp = hresp; rd = hrdata;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hexcl = 1'b0;
        hwdata = '0; hmaster = '0; hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011;
        hmastlock = 1'b0; err_mode = 1'b0; waits = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hexokay", 32'(hexokay), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LDREX/STREX pair on master 0, then a second STREX without reservation
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("t1_ldrex_tr", 32'(tr), 32'd2);
        chk("t1_ldrex_ok", 32'(ok), 32'd1);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'hA5A5);
        chk("t1_strex_tr", 32'(tr), 32'd2);
        chk("t1_strex_ok", 32'(ok), 32'd1);
        chk("t1_mem", mem[8'h40], 32'hA5A5);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'h1111);
        chk("t1_again_tr", 32'(tr), 32'd0);
        chk("t1_again_ok", 32'(ok), 32'd0);
        chk("t1_again_mem", mem[8'h40], 32'hA5A5);

        // STREX with no reservation is answered locally in one cycle
        xfer(8'd0, 32'h200, 1'b1, 1'b0, 32'h55);
        xfer(8'd0, 32'h200, 1'b1, 1'b1, 32'h1234);
        chk("t2_tr", 32'(tr), 32'd0);
        chk("t2_ok", 32'(ok), 32'd0);
        chk("t2_resp", 32'(resp), 32'd0);
        chk("t2_waits", 32'(wc), 32'd0);
        chk("t2_mem", mem[8'h80], 32'h55);
        xfer(8'd0, 32'h200, 1'b0, 1'b0, 32'h0);
        chk("t2_rdata", rd, 32'h55);

        // Other master writes a different granule, then the same granule
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        xfer(8'd1, 32'h104, 1'b1, 1'b0, 32'h7);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'h8);
        chk("t3a_tr", 32'(tr), 32'd2);
        chk("t3a_ok", 32'(ok), 32'd1);
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        xfer(8'd1, 32'h100, 1'b1, 1'b0, 32'h9);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'hA);
        chk("t3b_tr", 32'(tr), 32'd0);
        chk("t3b_ok", 32'(ok), 32'd0);
        chk("t3b_mem", mem[8'h40], 32'h9);

        // Byte offset inside the reserved granule still matches
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        xfer(8'd0, 32'h102, 1'b1, 1'b1, 32'hB);
        chk("gran_tr", 32'(tr), 32'd2);
        chk("gran_ok", 32'(ok), 32'd1);

        // Two masters reserve the same granule; the first STREX wins
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        xfer(8'd1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("t4_ld1_ok", 32'(ok), 32'd1);
        xfer(8'd1, 32'h100, 1'b1, 1'b1, 32'hC);
        chk("t4_st1_tr", 32'(tr), 32'd2);
        chk("t4_st1_ok", 32'(ok), 32'd1);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'hD);
        chk("t4_st0_tr", 32'(tr), 32'd0);
        chk("t4_st0_ok", 32'(ok), 32'd0);

        // Out-of-range master never holds a reservation
        xfer(8'd5, 32'h100, 1'b0, 1'b1, 32'h0);
        xfer(8'd5, 32'h100, 1'b1, 1'b1, 32'hE);
        chk("m5_tr", 32'(tr), 32'd0);

        // Plain write completing in the cycle the STREX address is accepted
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        hmaster = 8'd1; haddr = 32'h100; hwrite = 1'b1; hexcl = 1'b0; htrans = 2'b10;
        @(posedge clk);
        @(negedge clk);
        hwdata = 32'h77; hmaster = 8'd0; hexcl = 1'b1; htrans = 2'b10;
        #1;
        chk("t5_fwd_tr", 32'(dst_htrans), 32'd0);
        chk("t5_plain_ready", 32'(hready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        htrans = 2'b00; hexcl = 1'b0; hwdata = 32'h88;
        chk("t5_ready", 32'(hready), 32'd1);
        chk("t5_ok", 32'(hexokay), 32'd0);
        chk("t5_resp", 32'(hresp), 32'd0);
        @(negedge clk);
        chk("t5_mem", mem[8'h40], 32'h77);

        // ERROR response to LDREX sets no reservation
        err_mode = 1'b1;
        xfer(8'd0, 32'h300, 1'b0, 1'b1, 32'h0);
        chk("t6_resp", 32'(resp), 32'd1);
        chk("t6_ok", 32'(ok), 32'd0);
        chk("t6_waits", 32'(wc), 32'd1);
        err_mode = 1'b0;
        xfer(8'd0, 32'h300, 1'b1, 1'b1, 32'hF);
        chk("t6_strex_tr", 32'(tr), 32'd0);

        // Reset in the middle of a wait state drops reservations
        xfer(8'd0, 32'h100, 1'b0, 1'b1, 32'h0);
        waits = 4'd3;
        hmaster = 8'd1; haddr = 32'h180; hwrite = 1'b0; hexcl = 1'b0; htrans = 2'b10;
        @(posedge clk);
        @(negedge clk);
        htrans = 2'b00;
        chk("t6_wait_ready", 32'(hready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(hready), 32'd1);
        chk("t6_rst_ok", 32'(hexokay), 32'd0);
        chk("t6_rst_resp", 32'(hresp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; waits = 4'd0;
        @(negedge clk);
        xfer(8'd0, 32'h100, 1'b1, 1'b1, 32'h99);
        chk("t6_after_rst_tr", 32'(tr), 32'd0);
        chk("t6_after_rst_ok", 32'(ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
